cam_pwr_seq: RTL



---
 rtl/cam_pwr_seq_if.sv | 22 ++
 rtl/cam_pwr_seq.sv | 136 +++++++++++++
 2 files changed

// File: rtl/cam_pwr_seq_if.sv
// cam_pwr_seq_if: command/status bundle between the command decoder and the power sequencer.
interface cam_pwr_seq_if #(parameter int NCH = 5);
  logic           cmd_valid;
  logic           cmd_on;
  logic [NCH-1:0] cmd_mask;
  logic           kill;
  logic           cmd_ready;
  logic [NCH-1:0] pwr_en;
  logic [NCH-1:0] cam_rst_n;
  logic           busy;
  logic           done;
  logic           aborted;
  logic [NCH-1:0] ch_on;
  modport master (
    output cmd_valid, cmd_on, cmd_mask, kill,
    input  cmd_ready, pwr_en, cam_rst_n, busy, done, aborted, ch_on
  );
  modport slave (
    input  cmd_valid, cmd_on, cmd_mask, kill,
    output cmd_ready, pwr_en, cam_rst_n, busy, done, aborted, ch_on
  );
endinterface

// File: rtl/cam_pwr_seq.sv
// cam_pwr_seq: ordered power/reset sequencer for NCH loads with a shared delay counter and kill override.
module cam_pwr_seq #(
  parameter int          NCH            = 5,
  parameter logic [31:0] PWR_SETTLE_CYC = 32'd5000000,
  parameter logic [31:0] RST_HOLD_CYC   = 32'd500000,
  parameter logic [31:0] STAGGER_CYC    = 32'd1000000,
  parameter int          CNT_W          = 32
) (
  input logic         clk,
  input logic         rst_n,
  cam_pwr_seq_if.slave bus
);
  localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
  localparam logic [IW-1:0]    LAST       = IW'(NCH - 1);
  localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(PWR_SETTLE_CYC - 32'd1);
  localparam logic [CNT_W-1:0] HOLD_END   = CNT_W'(RST_HOLD_CYC - 32'd1);
  localparam logic [CNT_W-1:0] GAP_END    = CNT_W'(STAGGER_CYC - 32'd1);
  typedef enum logic [2:0] {IDLE, SCAN, ON_SETTLE, OFF_HOLD, GAP, DONE} state_t;
  state_t           state_q;
  logic             on_q;
  logic [NCH-1:0]   mask_q;
  logic [NCH-1:0]   pwr_en_q;
  logic [NCH-1:0]   rst_n_q;
  logic [IW-1:0]    idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cmd_ready_q;
  logic             busy_q;
  logic             done_q;
  logic             aborted_q;
  logic             last;
  logic             act;
  logic [IW-1:0]    idx_step;
  always_comb begin
    last     = on_q ? idx_q == LAST : idx_q == '0;
    idx_step = on_q ? idx_q + IW'(1) : idx_q - IW'(1);
    act      = mask_q[idx_q] & (on_q ? ~(pwr_en_q[idx_q] & rst_n_q[idx_q]) : pwr_en_q[idx_q]);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      on_q        <= 1'b0;
      mask_q      <= '0;
      pwr_en_q    <= '0;
      rst_n_q     <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else if (bus.kill) begin
      state_q     <= IDLE;
      pwr_en_q    <= '0;
      rst_n_q     <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= state_q != IDLE;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            on_q        <= bus.cmd_on;
            mask_q      <= bus.cmd_mask;
            idx_q       <= bus.cmd_on ? '0 : LAST;
            state_q     <= SCAN;
            busy_q      <= 1'b1;
            cmd_ready_q <= 1'b0;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        SCAN: begin
          if (act) begin
            cnt_q          <= '0;
            rst_n_q[idx_q] <= 1'b0;
            if (on_q) pwr_en_q[idx_q] <= 1'b1;
            state_q <= on_q ? ON_SETTLE : OFF_HOLD;
          end else if (last) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_step;
          end
        end
        ON_SETTLE: begin
          if (cnt_q == SETTLE_END) begin
            rst_n_q[idx_q] <= 1'b1;
            cnt_q          <= '0;
            state_q        <= GAP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        OFF_HOLD: begin
          if (cnt_q == HOLD_END) begin
            pwr_en_q[idx_q] <= 1'b0;
            cnt_q           <= '0;
            state_q         <= GAP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_q == GAP_END) begin
            cnt_q <= '0;
            if (last) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_step;
              state_q <= SCAN;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.pwr_en    = pwr_en_q;
  assign bus.cam_rst_n = rst_n_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;
  assign bus.ch_on     = pwr_en_q & rst_n_q;
endmodule
